// File: rtl/hwpe_stream_package.sv
// Shared HWPE-Stream control types for the serializer/deserializer pair.
package hwpe_stream_package;

  localparam int unsigned SERDES_FIELD_W = 10;

  typedef struct packed {
    logic [SERDES_FIELD_W-1:0] first_stream;
    logic                      clear_serdes_state;
    logic [SERDES_FIELD_W-1:0] nb_contig_m1;
  } ctrl_serdes_t;

endpackage

// File: rtl/hwpe_stream_deserialize_slot.sv
// One-entry output buffer: holds a packet until the consumer takes it.
module hwpe_stream_deserialize_slot #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk_i,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [STRB_WIDTH-1:0] load_strb,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [STRB_WIDTH-1:0] pop_strb,
  output logic                  pop_valid,
  output logic                  free
);

  logic                  full_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;

  // Load wins over pop so a same-cycle pop+load keeps the slot full with new data;
  // a full unpopped slot is never overwritten because the top only loads when free.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      full_q <= 1'b0;
      data_q <= '0;
      strb_q <= '0;
    end else if (load) begin
      full_q <= 1'b1;
      data_q <= load_data;
      strb_q <= load_strb;
    end else if (pop_ready) begin
      full_q <= 1'b0;
    end
  end

  assign free      = ~full_q | pop_ready;
  assign pop_valid = full_q;
  assign pop_data  = data_q;
  assign pop_strb  = strb_q;

endmodule

// File: rtl/hwpe_stream_deserialize.sv
// Round-robin deserializer: spreads one input stream over NB_OUT_STREAMS outputs,
// nb_contig_m1+1 contiguous packets per output before moving to the next.
module hwpe_stream_deserialize
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_OUT_STREAMS = 2,
  parameter int unsigned CONTIG_LIMIT   = 1024,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH/8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     clear_i,
  input  ctrl_serdes_t                             ctrl_i,
  input  logic [DATA_WIDTH-1:0]                    push_data,
  input  logic [STRB_WIDTH-1:0]                    push_strb,
  input  logic                                     push_valid,
  output logic                                     push_ready,
  output logic [NB_OUT_STREAMS-1:0][DATA_WIDTH-1:0] pop_data,
  output logic [NB_OUT_STREAMS-1:0][STRB_WIDTH-1:0] pop_strb,
  output logic [NB_OUT_STREAMS-1:0]                 pop_valid,
  input  logic [NB_OUT_STREAMS-1:0]                 pop_ready
);

  localparam int unsigned CONTIG_W = $clog2(CONTIG_LIMIT);
  localparam int unsigned STREAM_W = $clog2(NB_OUT_STREAMS);

  logic                      clr;
  logic                      accept;
  logic [NB_OUT_STREAMS-1:0] free;
  logic [NB_OUT_STREAMS-1:0] load;
  logic [STREAM_W-1:0]       stream_cnt_q;
  logic [CONTIG_W-1:0]       contig_cnt_q;
  logic [CONTIG_W-1:0]       nb_m1;
  logic                      first_ok;

  assign clr      = rst_i | clear_i;
  assign nb_m1    = CONTIG_W'(ctrl_i.nb_contig_m1);
  assign first_ok = ctrl_i.first_stream < SERDES_FIELD_W'(NB_OUT_STREAMS);

  // Ready only reflects the targeted slot; it never looks at push_valid.
  assign push_ready = free[stream_cnt_q] & ~ctrl_i.clear_serdes_state & ~clr;
  assign accept     = push_valid & push_ready;

  // Group/stream counters; a state clear overrides any accept in the same cycle.
  // Using '<' means a shrunken nb_contig_m1 below the current count closes the group.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      stream_cnt_q <= '0;
      contig_cnt_q <= '0;
    end else if (ctrl_i.clear_serdes_state) begin
      stream_cnt_q <= first_ok ? STREAM_W'(ctrl_i.first_stream) : '0;
      contig_cnt_q <= '0;
    end else if (accept) begin
      if (contig_cnt_q < nb_m1) begin
        contig_cnt_q <= contig_cnt_q + CONTIG_W'(1);
      end else begin
        contig_cnt_q <= '0;
        stream_cnt_q <= (stream_cnt_q == STREAM_W'(NB_OUT_STREAMS-1)) ? '0
                      : stream_cnt_q + STREAM_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : g_slot
    assign load[i] = accept & (stream_cnt_q == STREAM_W'(i));

    hwpe_stream_deserialize_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH)
    ) i_slot (
      .clk_i     (clk_i),
      .clr       (clr),
      .load      (load[i]),
      .load_data (push_data),
      .load_strb (push_strb),
      .pop_ready (pop_ready[i]),
      .pop_data  (pop_data[i]),
      .pop_strb  (pop_strb[i]),
      .pop_valid (pop_valid[i]),
      .free      (free[i])
    );
  end

endmodule

// File: tb/tb_hwpe_stream_deserialize.sv
// Bench: three deserializer instances (N=2,3,4); one is selected per test.
module tb_hwpe_stream_deserialize;
  import hwpe_stream_package::*;

  logic clk = 0;
  always #5 clk = ~clk;

  logic         rst, clr, pv;
  logic [31:0]  pd;
  logic [3:0]   ps;
  logic [3:0]   rdy;
  ctrl_serdes_t ctrl;
  int           sel;
  bit           chk_en = 0;
  int           checks = 0, fails = 0;

  logic [1:0][31:0] w2_d; logic [1:0][3:0] w2_s; logic [1:0] w2_v; logic w2_r;
  logic [2:0][31:0] w3_d; logic [2:0][3:0] w3_s; logic [2:0] w3_v; logic w3_r;
  logic [3:0][31:0] w4_d; logic [3:0][3:0] w4_s; logic [3:0] w4_v; logic w4_r;

  hwpe_stream_deserialize #(.NB_OUT_STREAMS(2)) u2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .ctrl_i(ctrl),
    .push_data(pd), .push_strb(ps), .push_valid(pv && sel == 0), .push_ready(w2_r),
    .pop_data(w2_d), .pop_strb(w2_s), .pop_valid(w2_v), .pop_ready(rdy[1:0]));
  hwpe_stream_deserialize #(.NB_OUT_STREAMS(3)) u3 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .ctrl_i(ctrl),
    .push_data(pd), .push_strb(ps), .push_valid(pv && sel == 1), .push_ready(w3_r),
    .pop_data(w3_d), .pop_strb(w3_s), .pop_valid(w3_v), .pop_ready(rdy[2:0]));
  hwpe_stream_deserialize #(.NB_OUT_STREAMS(4)) u4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .ctrl_i(ctrl),
    .push_data(pd), .push_strb(ps), .push_valid(pv && sel == 2), .push_ready(w4_r),
    .pop_data(w4_d), .pop_strb(w4_s), .pop_valid(w4_v), .pop_ready(rdy[3:0]));

  logic [3:0][31:0] d_m; logic [3:0][3:0] s_m; logic [3:0] v_m; logic r_m;
  always_comb begin
    d_m = '0; s_m = '0; v_m = '0; r_m = 1'b0;
    case (sel)
      0: begin d_m[1:0] = w2_d; s_m[1:0] = w2_s; v_m[1:0] = w2_v; r_m = w2_r; end
      1: begin d_m[2:0] = w3_d; s_m[2:0] = w3_s; v_m[2:0] = w3_v; r_m = w3_r; end
      default: begin d_m = w4_d; s_m = w4_s; v_m = w4_v; r_m = w4_r; end
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: each output is a FIFO of packets it still owes; a packet joins the FIFO of
  // the output the round-robin rule assigns when it is accepted.
  logic [35:0] mq [4][$];
  logic [31:0] lg [4][$];
  int tgt = 0, cnt = 0;

  always @(negedge clk) if (chk_en) begin
    int n;
    bit er;
    n = sel + 2;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("out%0d_valid", i), 64'(v_m[i]), 64'(mq[i].size() != 0));
      if (mq[i].size() != 0) chk($sformatf("out%0d_data", i), 64'({d_m[i], s_m[i]}), 64'(mq[i][0]));
    end
    er = !rst && !clr && !ctrl.clear_serdes_state && (mq[tgt].size() == 0 || rdy[tgt]);
    chk("push_ready", 64'(r_m), 64'(er));
    for (int i = 0; i < n; i++)
      if (mq[i].size() != 0 && rdy[i]) begin
        void'(mq[i].pop_front());
        lg[i].push_back(d_m[i]);
      end
    if (rst || clr) begin
      for (int i = 0; i < 4; i++) begin mq[i].delete(); lg[i].delete(); end
      tgt = 0; cnt = 0;
    end else if (ctrl.clear_serdes_state) begin
      tgt = (ctrl.first_stream < n) ? int'(ctrl.first_stream) : 0;
      cnt = 0;
    end else if (pv && er) begin
      mq[tgt].push_back({pd, ps});
      if (cnt < int'(ctrl.nb_contig_m1)) cnt++;
      else begin cnt = 0; tgt = (tgt + 1) % n; end
    end
  end

  task automatic push(input logic [31:0] d, output int tries);
    bit acc;
    tries = 0;
    pd = d; ps = d[3:0]; pv = 1'b1;
    do begin
      @(negedge clk); acc = r_m; tries++;
      @(posedge clk); #1;
    end while (!acc && tries < 200);
    if (!acc) chk("push_timeout", 64'(0), 64'(1));
    pv = 1'b0;
  endtask

  task automatic do_reset(input int s);
    sel = s; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_serdes(input int fs);
    ctrl.first_stream = 10'(fs); ctrl.clear_serdes_state = 1'b1;
    @(posedge clk); #1 ctrl.clear_serdes_state = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  bit done = 0;
  initial begin
    int t;
    int tsum;
    rst = 1; clr = 0; pv = 0; pd = 0; ps = 0; rdy = 4'hF; ctrl = '0; sel = 0;
    @(posedge clk); #1 chk_en = 1;
    @(negedge clk); chk("rst_push_ready", 64'(r_m), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", 64'(v_m), 0);
    chk("rst_data", 64'(|{w2_d, w2_s, w3_d, w4_d}), 0);
    @(posedge clk); #1;

    // T1: N=2 per-packet round robin
    do_reset(0); ctrl.nb_contig_m1 = 0; rdy = 4'hF; tsum = 0;
    push(32'hA0, t); tsum += t; push(32'hB0, t); tsum += t;
    push(32'hC0, t); tsum += t; push(32'hD0, t); tsum += t;
    repeat (3) @(negedge clk);
    chk("t1_no_stall", 64'(tsum), 4);
    chk("t1_out0_n", 64'(lg[0].size()), 2); chk("t1_out0_a", 64'(lg[0][0]), 'hA0);
    chk("t1_out0_c", 64'(lg[0][1]), 'hC0);
    chk("t1_out1_n", 64'(lg[1].size()), 2); chk("t1_out1_b", 64'(lg[1][0]), 'hB0);
    chk("t1_out1_d", 64'(lg[1][1]), 'hD0);
    @(posedge clk); #1;

    // T2: N=3 groups of 3
    do_reset(1); ctrl.nb_contig_m1 = 2;
    for (int k = 0; k < 9; k++) push(32'(k), t);
    repeat (3) @(negedge clk);
    for (int o = 0; o < 3; o++) begin
      chk($sformatf("t2_out%0d_n", o), 64'(lg[o].size()), 3);
      for (int j = 0; j < 3; j++) chk($sformatf("t2_out%0d_%0d", o, j), 64'(lg[o][j]), 64'(o*3 + j));
    end
    @(posedge clk); #1;
    push(32'h9, t);
    repeat (2) @(negedge clk);
    chk("t2_wrap_to_out0", 64'(lg[0][3]), 9);
    @(posedge clk); #1;

    // T3: N=2, out1 stalled
    do_reset(0); ctrl.nb_contig_m1 = 0; rdy = 4'b0001; tsum = 0;
    push(32'h10, t); tsum += t; push(32'h11, t); tsum += t; push(32'h12, t); tsum += t;
    chk("t3_no_stall", 64'(tsum), 3);
    fork
      push(32'h13, t);
      begin repeat (3) @(posedge clk); #2 rdy = 4'b0011; end
    join
    chk("t3_stall_tries", 64'(t), 4);
    repeat (3) @(negedge clk);
    chk("t3_out0_n", 64'(lg[0].size()), 2); chk("t3_out0_p2", 64'(lg[0][1]), 'h12);
    chk("t3_out1_n", 64'(lg[1].size()), 2); chk("t3_out1_p1", 64'(lg[1][0]), 'h11);
    chk("t3_out1_p3", 64'(lg[1][1]), 'h13);
    @(posedge clk); #1;

    // T4: N=4 state clear mid-group
    do_reset(2); ctrl.nb_contig_m1 = 2; rdy = 4'hF;
    push(32'h20, t); push(32'h21, t);
    ctrl.first_stream = 2; ctrl.clear_serdes_state = 1; pd = 32'h99; pv = 1;
    @(negedge clk); chk("t4_blocked", 64'(r_m), 0);
    @(posedge clk); #1 ctrl.clear_serdes_state = 0; pv = 0;
    push(32'h22, t); push(32'h23, t); push(32'h24, t); push(32'h25, t);
    pulse_serdes(7);
    push(32'h26, t);
    repeat (3) @(negedge clk);
    chk("t4_out2_n", 64'(lg[2].size()), 3); chk("t4_out2_0", 64'(lg[2][0]), 'h22);
    chk("t4_out2_2", 64'(lg[2][2]), 'h24);
    chk("t4_out3_n", 64'(lg[3].size()), 1); chk("t4_out3_0", 64'(lg[3][0]), 'h25);
    chk("t4_out0_n", 64'(lg[0].size()), 3); chk("t4_out0_fs7", 64'(lg[0][2]), 'h26);
    @(posedge clk); #1;

    // T5: soft clear with full slots
    do_reset(0); ctrl.nb_contig_m1 = 0; rdy = 4'h0;
    push(32'h30, t); push(32'h31, t);
    clr = 1;
    @(negedge clk); chk("t5_ready_in_clr", 64'(r_m), 0); chk("t5_full", 64'(v_m), 3);
    @(posedge clk); #1 clr = 0;
    @(negedge clk); chk("t5_valid_cleared", 64'(v_m), 0);
    @(posedge clk); #1 rdy = 4'hF;
    push(32'h33, t);
    repeat (2) @(negedge clk);
    chk("t5_out0_n", 64'(lg[0].size()), 1); chk("t5_out0_first", 64'(lg[0][0]), 'h33);
    chk("t5_out1_n", 64'(lg[1].size()), 0);
    @(posedge clk); #1;

    // T6: random traffic on N=3
    do_reset(1);
    fork
      begin
        for (int k = 0; k < 10000; k++) begin
          if ($urandom_range(0, 99) == 0) pulse_serdes($urandom_range(0, 5));
          if (k % 50 == 0) ctrl.nb_contig_m1 = 10'($urandom_range(0, 3));
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          push(32'h5000_0000 | 32'(k), t);
        end
        done = 1;
      end
      begin
        while (!done) begin @(posedge clk); #1 rdy = 4'($urandom); end
      end
    join
    rdy = 4'hF;
    repeat (5) @(negedge clk);
    chk("t6_all_delivered", 64'(lg[0].size() + lg[1].size() + lg[2].size()), 10000);
    chk("t6_drained", 64'(v_m), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
